// File: rtl/divider_unit_pkg.sv
// divider_unit_pkg: shared decode types, FSM states and constants for the RV32M divider.
package divider_unit_pkg;
    localparam int XLEN = 32;
    localparam int TAG_W = 5;
    localparam int DIV_ITER = XLEN;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic {ALU_DIV, ALU_REM} AluSel;
    typedef enum logic {OP_UNSIGNED, OP_SIGNED} SignSel;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} DivState;

    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x, input logic sg);
        return (sg && x[XLEN-1]) ? -x : x;
    endfunction
endpackage

// File: rtl/divider_unit_div_step.sv
// div_step: one combinational radix-2 restoring iteration on a 33-bit partial remainder.
module div_step
    import divider_unit_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_rem,
    output logic [W-1:0] o_quo
);
    logic [W:0] w_shift;
    logic [W:0] w_diff;
    assign w_shift = {i_rem[W-1:0], i_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // A set MSB of the difference means the trial subtraction went negative: restore.
    assign o_rem   = w_diff[W] ? w_shift : w_diff;
    assign o_quo   = {i_quo[W-2:0], ~w_diff[W]};
endmodule

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle RV32M DIV/DIVU/REM/REMU with valid/ready handshake.
// Special cases (divide by zero, signed overflow) bypass the iteration loop.
module divider_unit
    import divider_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_is_rem,
    input  logic             i_signed,
    input  logic [XLEN-1:0]  i_dividend,
    input  logic [XLEN-1:0]  i_divisor,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag
);
    DivState          r_state;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [5:0]       r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN:0]    w_rem;
    logic [XLEN-1:0]  w_quo;
    logic             w_div0;
    logic             w_ovf;

    div_step #(.W(XLEN)) u_step (
        .i_rem(r_rem),
        .i_quo(r_quo),
        .i_divisor(r_div),
        .o_rem(w_rem),
        .o_quo(w_quo)
    );

    assign w_div0   = (i_divisor == '0);
    assign w_ovf    = i_signed && (i_dividend == DIV_OVF_DIVIDEND) && (i_divisor == '1);
    assign o_ready  = (r_state == IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_tag    = r_tag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_valid) begin
                    r_is_rem <= i_is_rem;
                    r_tag    <= i_tag;
                    if (w_div0 || w_ovf) begin
                        r_result <= w_div0 ? (i_is_rem ? i_dividend : '1)
                                           : (i_is_rem ? '0 : DIV_OVF_DIVIDEND);
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_quo   <= f_mag(i_dividend, i_signed);
                        r_div   <= f_mag(i_divisor, i_signed);
                        r_neg_q <= i_signed && (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
                        r_neg_r <= i_signed && i_dividend[XLEN-1];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(DIV_ITER - 1)) r_state <= FIXUP;
                end
                FIXUP: begin
                    r_result <= r_is_rem ? (r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0])
                                         : (r_neg_q ? -r_quo : r_quo);
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: if (i_ready) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed checks of results, latency, backpressure, flush and reset.
module tb_divider_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_is_rem = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic [4:0]  i_tag = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc;
    logic [31:0] held;

    divider_unit dut (
        .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_is_rem(i_is_rem), .i_signed(i_signed),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Present a request for one edge, then count edges until o_valid (bounded).
    task automatic req(input logic rem, input logic sg, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        i_valid = 1'b1; i_is_rem = rem; i_signed = sg;
        i_dividend = a; i_divisor = b; i_tag = tg;
        @(posedge clk); #1;
        i_valid = 1'b0;
        cyc = 1;
        while (!o_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic pop();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic op(input string name, input logic rem, input logic sg, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        req(rem, sg, a, b, 5'd3);
        chk(name, o_result, exp);
        chk({name, "_lat"}, 32'(cyc), 32'(exp_cyc));
        pop();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        reset_n = 1'b1;
        req(1'b0, 1'b0, 32'd100, 32'd7, 5'd21);
        chk("divu_100_7", o_result, 32'd14);
        chk("divu_lat", 32'(cyc), 32'd34);
        chk("divu_tag", {27'd0, o_tag}, 32'd21);
        pop();
        chk("pop_valid", {31'd0, o_valid}, 32'd0);
        chk("pop_ready", {31'd0, o_ready}, 32'd1);
        op("remu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 34);
        op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        op("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        op("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        op("remu_5_0", 1'b1, 1'b0, 32'd5, 32'd0, 32'd5, 1);
        op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        op("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        op("divu_ovf_ops", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        op("divu_big", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
        // Backpressure: result, tag and in_ready must hold while out_ready is low.
        req(1'b0, 1'b0, 32'd100, 32'd7, 5'd9);
        held = o_result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_result", o_result, held);
            chk("bp_tag", {27'd0, o_tag}, 32'd9);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
        end
        chk("bp_value", held, 32'd14);
        pop();
        // Flush at CALC iteration 15.
        i_valid = 1'b1; i_is_rem = 1'b0; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("calc_ready", {31'd0, o_ready}, 32'd0);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_ready", {31'd0, o_ready}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_valid) cyc++;
        end
        chk("flush_no_valid", 32'(cyc), 32'd0);
        // A request presented together with flush must be dropped.
        i_valid = 1'b1; i_flush = 1'b1; i_dividend = 32'd5; i_divisor = 32'd0;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flushreq_ready", {31'd0, o_ready}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (o_valid) cyc++;
        end
        chk("flushreq_no_valid", 32'(cyc), 32'd0);
        // Reset while in FIXUP.
        i_valid = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7; i_tag = 5'd17;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("fixrst_ready", {31'd0, o_ready}, 32'd1);
        chk("fixrst_valid", {31'd0, o_valid}, 32'd0);
        chk("fixrst_result", o_result, 32'd0);
        chk("fixrst_tag", {27'd0, o_tag}, 32'd0);
        op("post_rst_div", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
